// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state codes and small helpers for the iterative HI/LO multiply/divide unit.
package mdu_defs;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // Signed ops (MULT, DIV) have a zero in the low op bit.
    function automatic logic is_signed_op(input mdu_op_e op);
        return !op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        // The partial remainder stays below the divisor, so a WIDTH-bit difference is exact.
        diff    = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (shifted >= {1'b0, opnd}) begin
                next_hi = diff;
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: magnitudes are iterated for WIDTH cycles, signs fixed up at the end.
module mul_div_unit
    import mdu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e       state;
    mdu_op_e          op_q;
    logic [CW-1:0]    count;
    logic             sign_res;
    logic             sign_rem;
    logic             rt_zero;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             signed_in;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign signed_in = is_signed_op(mdu_op_e'(op));
    assign abs_rs    = (signed_in && rs[WIDTH-1]) ? -rs : rs;
    assign abs_rt    = (signed_in && rt[WIDTH-1]) ? -rt : rt;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_q[1]),
        .opnd    (opnd),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign fix-up applied in FIX; divide-by-zero forces an all-ones quotient.
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (!op_q[1]) begin
            if (is_signed_op(op_q) && sign_res)
                {res_hi, res_lo} = -{acc_hi, acc_lo};
        end else begin
            if (rt_zero)
                res_lo = '1;
            else if (is_signed_op(op_q) && sign_res)
                res_lo = -acc_lo;
            if (is_signed_op(op_q) && sign_rem)
                res_hi = -acc_hi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= MDU_MULT;
            count    <= '0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            rt_zero  <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            // NOTE: non-blocking defaults make done/div_zero single-cycle pulses.
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_q     <= mdu_op_e'(op);
                        sign_res <= rs[WIDTH-1] ^ rt[WIDTH-1];
                        sign_rem <= rs[WIDTH-1];
                        rt_zero  <= (rt == '0);
                        acc_hi   <= '0;
                        // Divide iterates the dividend through LO; multiply shifts the multiplier out of LO.
                        opnd     <= op[1] ? abs_rt : abs_rs;
                        acc_lo   <= op[1] ? abs_rs : abs_rt;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    done     <= 1'b1;
                    div_zero <= op_q[1] & rt_zero;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, multi-cycle corner sequences, random ops vs a reference model.
module tb_mul_div_unit;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin
                p = sa * sb;
                return {1'b0, p[63:0]};
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op and follow it to done. inject_kind: 0 none, 1 stray start, 2 MTHI while busy, 3 MTHI with start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input int inject_kind, input string tag,
                         output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        int lat;
        logic early_idle;
        logic hilo_moved;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        lat = 0;
        early_idle = 1'b0;
        hilo_moved = 1'b0;
        @(negedge clk);
        op = o;
        rs = a;
        rt = b;
        start = 1'b1;
        if (inject_kind == 3) begin
            hi_we = 1'b1;
            wdata = 32'h0000_CAFE;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
        if (inject_kind == 3) check({tag, "_write_with_start"}, {32'd0, hi}, 64'h0000_CAFE);
        hold_hi = hi;
        hold_lo = lo;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            hi_we = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) early_idle = 1'b1;
            if (hi !== hold_hi || lo !== hold_lo) hilo_moved = 1'b1;
            if (c == inject_at && inject_kind == 1) begin
                start = 1'b1;
                op = ~o;
                rs = ~a;
                rt = a ^ 32'h5555_5555;
            end
            if (c == inject_at && inject_kind == 2) begin
                hi_we = 1'b1;
                wdata = 32'h0000_1234;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_held"}, {63'd0, early_idle}, 64'd0);
        check({tag, "_hilo_held_in_run"}, {63'd0, hilo_moved}, 64'd0);
        check({tag, "_busy_clear_at_done"}, {63'd0, busy}, 64'd0);
        rhi = hi;
        rlo = lo;
        rdz = div_zero;
        @(posedge clk);
        #1;
        check({tag, "_done_single_pulse"}, {62'd0, done, div_zero}, 64'd0);
    endtask

    vec_t        vecs[10];
    logic [31:0] rhi;
    logic [31:0] rlo;
    logic        rdz;
    logic [64:0] exp_r;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b11, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[6] = '{2'b10, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9] = '{2'b00, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        rs = '0;
        rt = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #12;
        check("reset_outputs", {29'd0, busy, done, div_zero, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, $sformatf("vec%0d", i), rhi, rlo, rdz);
            check($sformatf("vec%0d_hilo", i), {rhi, rlo}, {vecs[i].ehi, vecs[i].elo});
            check($sformatf("vec%0d_div_zero", i), {63'd0, rdz}, {63'd0, vecs[i].edz});
        end

        // Stray start at cycle 5 of an op is ignored.
        do_op(2'b01, 32'h0001_0003, 32'h0000_0007, 5, 1, "ignore_start", rhi, rlo, rdz);
        check("ignore_start_result", {rhi, rlo}, 64'h0000_0000_0007_0015);
        check("ignore_start_no_relaunch", {63'd0, busy}, 64'd0);

        // MTHI while busy is dropped; HI is stable during RUN and later overwritten by the result.
        do_op(2'b11, 32'd1000, 32'd7, 4, 2, "mthi_busy", rhi, rlo, rdz);
        check("mthi_busy_result", {rhi, rlo}, {32'd6, 32'd142});
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mthi_idle_hi", {32'd0, hi}, 64'h0000_1234);
        check("mthi_idle_lo_untouched", {32'd0, lo}, 64'd142);
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

        // Write together with start: write lands, then the result overwrites it.
        do_op(2'b00, 32'd12, 32'hFFFF_FFFE, 0, 3, "write_with_start", rhi, rlo, rdz);
        check("write_with_start_result", {rhi, rlo}, 64'hFFFF_FFFF_FFFF_FFE8);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        op = 2'b01;
        rs = 32'h1234_5678;
        rt = 32'h9ABC_DEF0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("mid_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(2'b10, 32'hFFFF_FF00, 32'd16, 0, 0, "after_reset", rhi, rlo, rdz);
        check("after_reset_result", {rhi, rlo}, {32'd0, 32'hFFFF_FFF0});

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            exp_r = model(ro, ra, rb);
            do_op(ro, ra, rb, 0, 0, $sformatf("rand%0d", i), rhi, rlo, rdz);
            check($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), {rhi, rlo}, exp_r[63:0]);
            check($sformatf("rand%0d_div_zero", i), {63'd0, rdz}, {63'd0, exp_r[64]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
